// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values, FSM state encoding
// and the ALU operation select.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                           OP_XOR = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
                           OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPER,
        S_MEM,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_e;

    // Loads use PASS so that they share the ALU zero detect with arithmetic ops.
    function automatic alu_op_e alu_op_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hC) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: a is the accumulator, b the memory/immediate operand.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    // Carry is the unsigned overflow for ADD and the borrow (a < b) for SUB.
    always_comb begin
        result = b;
        carry  = 1'b0;
        sum    = '0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: FETCH -> OPER -> MEM over a single req/ready
// memory port, with Z/C flags and a sticky illegal-opcode halt.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    state_e            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] opr, opr_next;
    logic [DATA_W-1:0] acc, acc_next;
    logic [3:0]        ir, ir_next;
    logic              z, z_next;
    logic              c, c_next;
    logic              illegal_flag, illegal_next;

    logic [3:0]        opcode;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign opcode = mem_rdata[DATA_W-1 -: 4];

    // In OPER the only ALU user is LDI, which passes the immediate through.
    assign alu_op = (state == S_OPER) ? ALU_PASS : alu_op_for(ir);

    cpu_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op    (alu_op),
        .a     (acc),
        .b     (mem_rdata),
        .result(alu_result),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc           <= '0;
            opr          <= '0;
            acc          <= '0;
            ir           <= '0;
            z            <= 1'b0;
            c            <= 1'b0;
            illegal_flag <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            opr          <= opr_next;
            acc          <= acc_next;
            ir           <= ir_next;
            z            <= z_next;
            c            <= c_next;
            illegal_flag <= illegal_next;
        end
    end

    // Nothing advances without mem_ready, so every memory output holds during wait states.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        opr_next     = opr;
        acc_next     = acc;
        ir_next      = ir;
        z_next       = z;
        c_next       = c;
        illegal_next = illegal_flag;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_next = opcode;
                    pc_next = pc + ADDR_W'(1);
                    if (opcode == OP_NOP) begin
                        state_next = S_FETCH;
                    end else if (opcode == OP_HLT) begin
                        state_next = S_HALT;
                    end else if (is_illegal(opcode)) begin
                        illegal_next = 1'b1;
                        state_next   = S_HALT;
                    end else begin
                        state_next = S_OPER;
                    end
                end
            end
            S_OPER: begin
                if (mem_ready) begin
                    pc_next    = pc + ADDR_W'(1);
                    opr_next   = mem_rdata[ADDR_W-1:0];
                    state_next = S_FETCH;
                    case (ir)
                        OP_LDI: begin
                            acc_next = alu_result;
                            z_next   = alu_zero;
                        end
                        OP_JMP: pc_next = mem_rdata[ADDR_W-1:0];
                        OP_JZ:  if (z) pc_next = mem_rdata[ADDR_W-1:0];
                        OP_JC:  if (c) pc_next = mem_rdata[ADDR_W-1:0];
                        default: state_next = S_MEM;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    case (ir)
                        OP_LDA, OP_AND, OP_OR, OP_XOR: begin
                            acc_next = alu_result;
                            z_next   = alu_zero;
                        end
                        OP_ADD, OP_SUB: begin
                            acc_next = alu_result;
                            z_next   = alu_zero;
                            c_next   = alu_carry;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    assign mem_req   = (state != S_HALT);
    assign mem_we    = (state == S_MEM) && (ir == OP_STA);
    assign mem_addr  = (state == S_MEM) ? opr : pc;
    assign mem_wdata = acc;
    assign halted    = (state == S_HALT);
    assign illegal   = illegal_flag;
    assign pc_dbg    = pc;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random programs, every accepted
// memory access compared against an instruction-level reference model.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, halted, illegal;
    logic [7:0]  mem_addr, mem_wdata, pc_dbg;

    logic        reset2 = 1'b0;
    logic [15:0] mem_rdata2 = 16'h0000;
    logic        mem_ready2 = 1'b1;
    logic        mem_req2, mem_we2, halted2, illegal2;
    logic [11:0] mem_addr2, pc_dbg2;
    logic [15:0] mem_wdata2;

    logic [7:0]  mem [256];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    cpu_core dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .halted(halted), .illegal(illegal), .pc_dbg(pc_dbg)
    );

    cpu_core #(.DATA_W(16), .ADDR_W(12)) dut_wide (
        .clk(clk), .reset(reset2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .halted(halted2), .illegal(illegal2), .pc_dbg(pc_dbg2)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected access trace: {we, addr, wdata-for-writes}
    logic [16:0] exp_q[$];
    bit          exp_halted, exp_illegal;
    logic [7:0]  exp_pc;
    int          trace_idx = 0;
    bit          trace_on = 0;
    logic        stall_prev = 1'b0;
    logic [16:0] stall_val = '0;
    int          ready_mode = 0;
    int          we_stall_left = 0;
    int          write_count = 0;
    bit          wide_done = 0;

    // Wait-state generator: 0 always ready, 1 random, 2 stall the next writes
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (mem_we && we_stall_left > 0) begin
                    mem_ready = 1'b0;
                    we_stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
        endcase
    end

    always @(posedge clk) begin
        if (reset && mem_req && mem_we && mem_ready) begin
            mem[mem_addr] = mem_wdata;
            write_count++;
        end
    end

    // Access monitor: trace comparison and hold-while-stalled check
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                checkOutput("stall_hold", {mem_we, mem_addr, mem_wdata}, stall_val);
            if (trace_on && mem_req && mem_ready) begin
                if (trace_idx < exp_q.size())
                    checkOutput($sformatf("access%0d", trace_idx),
                                {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}, exp_q[trace_idx]);
                trace_idx++;
            end
            stall_prev = mem_req && !mem_ready;
            stall_val  = {mem_we, mem_addr, mem_wdata};
        end
    end

    // Instruction-level reference model run over a private copy of memory
    task automatic buildModel(input int limit);
        logic [7:0] m [256];
        logic [7:0] pc, acc, w, opnd, v;
        logic [8:0] s;
        logic [3:0] op;
        logic       z, c;
        for (int i = 0; i < 256; i++) m[i] = mem[i];
        pc = 8'h00; acc = 8'h00; z = 1'b0; c = 1'b0;
        exp_q.delete();
        exp_halted = 0;
        exp_illegal = 0;
        while (!exp_halted && exp_q.size() < limit) begin
            w = m[pc];
            exp_q.push_back({1'b0, pc, 8'h00});
            op = w[7:4];
            pc++;
            if (op == 4'h0) continue;
            if (op >= 4'hC) begin
                exp_halted = 1;
                exp_illegal = (op != 4'hF);
                break;
            end
            opnd = m[pc];
            exp_q.push_back({1'b0, pc, 8'h00});
            pc++;
            case (op)
                4'h1: begin acc = opnd; z = (acc == 0); end
                4'h9: pc = opnd;
                4'hA: if (z) pc = opnd;
                4'hB: if (c) pc = opnd;
                4'h3: begin
                    m[opnd] = acc;
                    exp_q.push_back({1'b1, opnd, acc});
                end
                default: begin
                    v = m[opnd];
                    exp_q.push_back({1'b0, opnd, 8'h00});
                    case (op)
                        4'h2: acc = v;
                        4'h4: begin s = acc + v; c = s[8]; acc = s[7:0]; end
                        4'h5: begin c = (acc < v); acc = acc - v; end
                        4'h6: acc = acc & v;
                        4'h7: acc = acc | v;
                        default: acc = acc ^ v;
                    endcase
                    z = (acc == 0);
                end
            endcase
        end
        exp_pc = pc;
    endtask

    task automatic applyStimulus(input string name, input int mode, input int limit, output int cycles);
        bit done;
        buildModel(limit);
        ready_mode = mode;
        trace_on = 0;
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        trace_idx = 0;
        trace_on = 1;
        reset = 1'b1;
        cycles = 0;
        done = 0;
        while (!done) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (halted) done = 1;
            else if (!exp_halted && trace_idx >= exp_q.size()) done = 1;
            else if (cycles >= 4000) begin
                checkOutput({name, "_timeout_halted"}, halted, 1);
                done = 1;
            end
        end
        trace_on = 0;
        if (exp_halted) begin
            checkOutput({name, "_trace_len"}, trace_idx, exp_q.size());
            checkOutput({name, "_halted"}, halted, 1);
            checkOutput({name, "_illegal"}, illegal, exp_illegal);
            checkOutput({name, "_pc"}, pc_dbg, exp_pc);
            checkOutput({name, "_req_off"}, mem_req, 0);
            if (mode == 0) checkOutput({name, "_cycles"}, cycles, exp_q.size());
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic loadAddSta();
        clearMem();
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h40; mem[3] = 8'h20;
        mem[4] = 8'h30; mem[5] = 8'h21; mem[6] = 8'hF0; mem[8'h20] = 8'h03;
    endtask

    // Wide core: all-NOP memory, PC must wrap 0xFFF -> 0x000
    initial begin
        repeat (3) @(posedge clk);
        #2 reset2 = 1'b1;
        for (int k = 1; k <= 4096; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4095) checkOutput("wide_pc_top", mem_addr2, 12'hFFF);
            if (k == 4096) begin
                checkOutput("wide_pc_wrap", mem_addr2, 12'h000);
                checkOutput("wide_pc_dbg_wrap", pc_dbg2, 12'h000);
                checkOutput("wide_not_halted", halted2, 0);
            end
        end
        wide_done = 1;
    end

    initial begin
        int cyc;
        int guard;
        logic [3:0] op;
        clearMem();
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_req", mem_req, 1);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_pc_dbg", pc_dbg, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_illegal", illegal, 0);

        loadAddSta();
        applyStimulus("add_sta", 0, 100, cyc);
        checkOutput("add_sta_cycles9", cyc, 9);
        checkOutput("add_sta_mem21", mem[8'h21], 8'h08);

        clearMem();
        mem[0] = 8'h10; mem[1] = 8'hFF; mem[2] = 8'h40; mem[3] = 8'h20; mem[4] = 8'hB0; mem[5] = 8'h40;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'hAA;
        mem[8'h40] = 8'hA0; mem[8'h41] = 8'h50;
        mem[8'h50] = 8'h30; mem[8'h51] = 8'h21; mem[8'h52] = 8'hF0;
        applyStimulus("add_carry_jc", 0, 100, cyc);
        checkOutput("add_carry_acc", mem[8'h21], 8'h00);
        checkOutput("add_carry_pc", pc_dbg, 8'h53);

        clearMem();
        mem[0] = 8'h10; mem[1] = 8'h02; mem[2] = 8'h50; mem[3] = 8'h20; mem[4] = 8'h30; mem[5] = 8'h21;
        mem[6] = 8'hB0; mem[7] = 8'h30; mem[8] = 8'hF0; mem[8'h20] = 8'h03;
        mem[8'h30] = 8'hA0; mem[8'h31] = 8'h40; mem[8'h32] = 8'hF0; mem[8'h40] = 8'hF0;
        applyStimulus("sub_borrow", 0, 100, cyc);
        checkOutput("sub_borrow_acc", mem[8'h21], 8'hFF);
        checkOutput("sub_borrow_pc", pc_dbg, 8'h33);

        loadAddSta();
        write_count = 0;
        we_stall_left = 3;
        applyStimulus("sta_stall", 2, 100, cyc);
        checkOutput("sta_stall_cycles", cyc, 12);
        checkOutput("sta_stall_writes", write_count, 1);
        checkOutput("sta_stall_mem21", mem[8'h21], 8'h08);

        clearMem();
        mem[0] = 8'h90; mem[1] = 8'h10; mem[8'h10] = 8'hC0;
        applyStimulus("illegal_op", 1, 100, cyc);
        repeat (5) @(negedge clk);
        checkOutput("illegal_held", illegal, 1);
        checkOutput("illegal_halted_held", halted, 1);
        checkOutput("illegal_req_held", mem_req, 0);
        checkOutput("illegal_pc_held", pc_dbg, 8'h11);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 256; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op >= 4'hC && op <= 4'hE && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 11));
                mem[i] = {op, 4'($urandom_range(0, 15))};
            end
            applyStimulus($sformatf("rand%0d", t), t % 2, 150, cyc);
        end

        loadAddSta();
        mem[8'h21] = 8'h5A;
        write_count = 0;
        ready_mode = 2;
        we_stall_left = 1000;
        reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        guard = 0;
        while (!mem_we && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_sta_reached", mem_we, 1);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_we_drop", mem_we, 0);
        checkOutput("abort_req", mem_req, 1);
        checkOutput("abort_addr", mem_addr, 0);
        checkOutput("abort_wdata", mem_wdata, 0);
        checkOutput("abort_pc", pc_dbg, 0);
        we_stall_left = 0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_write", write_count, 0);
        checkOutput("abort_mem_kept", mem[8'h21], 8'h5A);

        guard = 0;
        while (!wide_done && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("wide_done", wide_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
